// File: rtl/tcam_rule_loader.sv
`default_nettype none
// ============================================================================
// Module   : tcam_rule_loader
// Purpose  : Holds a small table of TCAM rules and, on a start pulse, writes
//            every enabled rule into the TCAM through a valid/ready write port.
//            Optionally clears the whole TCAM first.
// Ports    : clk, rst (async, active-low)
//            start                      - single-cycle load request
//            cfg_wr_en/slot/en/key/xmask/data, cfg_drop - rule table write port
//            set_addr/key/xmask/data/clr/valid, set_ready - TCAM write port
//            busy, done                 - load status
// Options  : define TCAM_RULE_LOADER_CLEAR_EN to clear every TCAM address
//            (set_clr=1) before the rules are loaded.
// Revision : 1.0 - initial release
// ============================================================================
module tcam_rule_loader #(
  parameter int TCAM_ADDR_WIDTH = 4,
  parameter int TCAM_KEY_WIDTH  = 96,
  parameter int TCAM_DATA_WIDTH = 4,
  parameter int N_RULES         = 3,
  parameter int BASE_ADDR       = 1,
  localparam int SLOT_W         = (N_RULES > 1) ? $clog2(N_RULES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cfg_wr_en,
  input  logic [SLOT_W-1:0]          cfg_slot,
  input  logic                       cfg_en,
  input  logic [TCAM_KEY_WIDTH-1:0]  cfg_key,
  input  logic [TCAM_KEY_WIDTH-1:0]  cfg_xmask,
  input  logic [TCAM_DATA_WIDTH-1:0] cfg_data,
  output logic                       cfg_drop,
  output logic [TCAM_ADDR_WIDTH-1:0] set_addr,
  output logic [TCAM_KEY_WIDTH-1:0]  set_key,
  output logic [TCAM_KEY_WIDTH-1:0]  set_xmask,
  output logic [TCAM_DATA_WIDTH-1:0] set_data,
  output logic                       set_clr,
  output logic                       set_valid,
  input  logic                       set_ready,
  output logic                       busy,
  output logic                       done
);

  // One extra bit so the index can reach N_RULES (or 2^TCAM_ADDR_WIDTH)
  // without wrapping, which is how the end of a pass is detected.
  localparam int IDX_W = TCAM_ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0]           c_n_rules = IDX_W'(N_RULES);
  localparam logic [SLOT_W:0]            c_n_slots = (SLOT_W + 1)'(N_RULES);
  localparam logic [TCAM_ADDR_WIDTH-1:0] c_base    = TCAM_ADDR_WIDTH'(BASE_ADDR);
`ifdef TCAM_RULE_LOADER_CLEAR_EN
  localparam logic [IDX_W-1:0]           c_n_addrs = IDX_W'(1) << TCAM_ADDR_WIDTH;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef TCAM_RULE_LOADER_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd1;
`endif
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Rule table
  logic                       r_en    [N_RULES];
  logic [TCAM_KEY_WIDTH-1:0]  r_key   [N_RULES];
  logic [TCAM_KEY_WIDTH-1:0]  r_xmask [N_RULES];
  logic [TCAM_DATA_WIDTH-1:0] r_data  [N_RULES];

  logic [1:0]       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [IDX_W-1:0] w_sel;
  logic             w_adv, w_do_clr, w_do_load;
  logic             w_slot_ok, w_cfg_ok;

  logic                       w_sl_en;
  logic [TCAM_KEY_WIDTH-1:0]  w_sl_key, w_sl_xmask;
  logic [TCAM_DATA_WIDTH-1:0] w_sl_data;

  logic                       w_valid_nxt, w_clr_nxt, w_busy_nxt, w_done_nxt, w_drop_nxt;
  logic [TCAM_ADDR_WIDTH-1:0] w_addr_nxt;
  logic [TCAM_KEY_WIDTH-1:0]  w_key_nxt, w_xmask_nxt;
  logic [TCAM_DATA_WIDTH-1:0] w_data_nxt;

  assign w_slot_ok = ({1'b0, cfg_slot} < c_n_slots);
  assign w_cfg_ok  = cfg_wr_en && !busy && w_slot_ok;
  // The current transaction (if any) is finished, so a new step may be taken.
  assign w_adv     = !set_valid || set_ready;

  // --------------------------------------------------------------------------
  // Rule table storage. Only the enables are reset; contents need no reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_RULES; i++) r_en[i] <= 1'b0;
    end else if (w_cfg_ok) begin
      for (int i = 0; i < N_RULES; i++)
        if (cfg_slot == SLOT_W'(i)) r_en[i] <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cfg_ok) begin
      for (int i = 0; i < N_RULES; i++) begin
        if (cfg_slot == SLOT_W'(i)) begin
          r_key[i]   <= cfg_key;
          r_xmask[i] <= cfg_xmask;
          r_data[i]  <= cfg_data;
        end
      end
    end
  end

  // Slot lookup with write bypass, so a start in the same cycle as a cfg
  // write presents the freshly written contents.
  always_comb begin
    w_sl_en    = 1'b0;
    w_sl_key   = '0;
    w_sl_xmask = '0;
    w_sl_data  = '0;
    for (int i = 0; i < N_RULES; i++) begin
      if (w_sel == IDX_W'(i)) begin
        if (w_cfg_ok && cfg_slot == SLOT_W'(i)) begin
          w_sl_en    = cfg_en;
          w_sl_key   = cfg_key;
          w_sl_xmask = cfg_xmask;
          w_sl_data  = cfg_data;
        end else begin
          w_sl_en    = r_en[i];
          w_sl_key   = r_key[i];
          w_sl_xmask = r_xmask[i];
          w_sl_data  = r_data[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register (all outputs are registered here too)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      set_valid <= 1'b0;
      set_clr   <= 1'b0;
      set_addr  <= '0;
      set_key   <= '0;
      set_xmask <= '0;
      set_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_drop  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      set_valid <= w_valid_nxt;
      set_clr   <= w_clr_nxt;
      set_addr  <= w_addr_nxt;
      set_key   <= w_key_nxt;
      set_xmask <= w_xmask_nxt;
      set_data  <= w_data_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      cfg_drop  <= w_drop_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Each step either presents the item at w_sel or, for a
  // disabled slot, spends one idle cycle on it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_do_clr    = 1'b0;
    w_do_load   = 1'b0;
    w_sel       = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef TCAM_RULE_LOADER_CLEAR_EN
          w_state_nxt = S_CLEAR;
          w_do_clr    = 1'b1;
`else
          w_state_nxt = S_LOAD;
          w_do_load   = 1'b1;
`endif
          w_idx_nxt   = IDX_W'(1);
        end
      end
`ifdef TCAM_RULE_LOADER_CLEAR_EN
      S_CLEAR: begin
        if (w_adv) begin
          if (r_idx == c_n_addrs) begin
            // Hand over to slot 0 directly so no bubble appears
            w_state_nxt = S_LOAD;
            w_do_load   = 1'b1;
            w_idx_nxt   = IDX_W'(1);
          end else begin
            w_do_clr  = 1'b1;
            w_sel     = r_idx;
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
`endif
      S_LOAD: begin
        if (w_adv) begin
          if (r_idx >= c_n_rules) begin
            w_state_nxt = S_DONE;
          end else begin
            w_do_load = 1'b1;
            w_sel     = r_idx;
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid_nxt = 1'b0;
    w_clr_nxt   = 1'b0;
    w_addr_nxt  = '0;
    w_key_nxt   = '0;
    w_xmask_nxt = '0;
    w_data_nxt  = '0;
    w_busy_nxt  = (w_state_nxt == S_LOAD);
`ifdef TCAM_RULE_LOADER_CLEAR_EN
    w_busy_nxt  = w_busy_nxt || (w_state_nxt == S_CLEAR);
`endif
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_drop_nxt  = cfg_wr_en && (busy || !w_slot_ok);
    if (busy && !w_adv) begin
      // Stalled: hold the pending transaction unchanged
      w_valid_nxt = set_valid;
      w_clr_nxt   = set_clr;
      w_addr_nxt  = set_addr;
      w_key_nxt   = set_key;
      w_xmask_nxt = set_xmask;
      w_data_nxt  = set_data;
    end else if (w_do_clr) begin
      w_valid_nxt = 1'b1;
      w_clr_nxt   = 1'b1;
      w_addr_nxt  = w_sel[TCAM_ADDR_WIDTH-1:0];
    end else if (w_do_load && w_sl_en) begin
      w_valid_nxt = 1'b1;
      w_addr_nxt  = c_base + w_sel[TCAM_ADDR_WIDTH-1:0];
      w_key_nxt   = w_sl_key;
      w_xmask_nxt = w_sl_xmask;
      w_data_nxt  = w_sl_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcam_rule_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcam_rule_loader
// Purpose  : Self-checking bench for tcam_rule_loader with a transaction-list
//            reference model and randomized tables / ready patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcam_rule_loader;
  localparam int AW = 4, KW = 96, DW = 4, NR = 3, BASE = 1;
`ifdef TCAM_RULE_LOADER_CLEAR_EN
  localparam int NCLR = 16;
`else
  localparam int NCLR = 0;
`endif

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic          cfg_wr_en = 1'b0, cfg_en = 1'b0;
  logic [1:0]    cfg_slot = '0;
  logic [KW-1:0] cfg_key = '0, cfg_xmask = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          set_ready = 1'b1;
  logic          cfg_drop, set_clr, set_valid, busy, done;
  logic [AW-1:0] set_addr;
  logic [KW-1:0] set_key, set_xmask;
  logic [DW-1:0] set_data;

  tcam_rule_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_wr_en(cfg_wr_en), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
    .cfg_key(cfg_key), .cfg_xmask(cfg_xmask), .cfg_data(cfg_data),
    .cfg_drop(cfg_drop), .set_addr(set_addr), .set_key(set_key),
    .set_xmask(set_xmask), .set_data(set_data), .set_clr(set_clr),
    .set_valid(set_valid), .set_ready(set_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [KW-1:0] key;
    logic [KW-1:0] xmask;
    logic [DW-1:0] data;
    logic          clr;
    int            cyc;
  } txn_t;

  txn_t exp_q[$], got_q[$];

  // Reference rule table
  bit            m_en    [NR];
  logic [KW-1:0] m_key   [NR];
  logic [KW-1:0] m_xmask [NR];
  logic [DW-1:0] m_data  [NR];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected write sequence: optional full clear, then enabled slots in order
  task automatic build_expected;
    txn_t t;
    exp_q.delete();
    for (int a = 0; a < NCLR; a++) begin
      t.addr = AW'(a); t.key = '0; t.xmask = '0; t.data = '0; t.clr = 1'b1; t.cyc = 0;
      exp_q.push_back(t);
    end
    for (int i = 0; i < NR; i++) begin
      if (m_en[i]) begin
        t.addr = AW'(BASE + i); t.key = m_key[i]; t.xmask = m_xmask[i];
        t.data = m_data[i]; t.clr = 1'b0; t.cyc = 0;
        exp_q.push_back(t);
      end
    end
  endtask

  // Idle-time table write; a slot beyond the table must be refused
  task automatic cfg_write(input int slot, input bit en, input logic [KW-1:0] key,
                           input logic [KW-1:0] xm, input logic [DW-1:0] data);
    bit exp_drop;
    exp_drop = (slot >= NR);
    cfg_slot = 2'(slot); cfg_en = en; cfg_key = key; cfg_xmask = xm; cfg_data = data;
    cfg_wr_en = 1'b1;
    tick;
    cfg_wr_en = 1'b0;
    vectors++;
    if (cfg_drop !== exp_drop) begin
      miscompares++;
      $display("FAIL cfg_drop_idle slot=%0d: got %b want %b", slot, cfg_drop, exp_drop);
    end
    if (!exp_drop) begin
      m_en[slot] = en; m_key[slot] = key; m_xmask[slot] = xm; m_data[slot] = data;
    end
  endtask

  function automatic logic [KW-1:0] rnd_key();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Runs one load and checks everything observed against the model.
  task automatic run_load(input int ready_pct, input int stall_addr, input bit wr_with_start,
                          input int restart_at, input int wr_busy_at,
                          output int done_cyc, output int stalls);
    bit fin, prev_stall, drop_pending, r;
    int cyc, stall_cnt, s;
    logic [201:0] prev, cur;
    txn_t t;
    got_q.delete();
    fin = 0; prev_stall = 0; drop_pending = 0; stalls = 0; stall_cnt = 0; prev = '0;
    start = 1'b1;
    if (wr_with_start) begin
      s = $urandom_range(NR - 1);
      cfg_slot = 2'(s); cfg_en = 1'($urandom()); cfg_key = rnd_key(); cfg_xmask = rnd_key();
      cfg_data = DW'($urandom()); cfg_wr_en = 1'b1;
      m_en[s] = cfg_en; m_key[s] = cfg_key; m_xmask[s] = cfg_xmask; m_data[s] = cfg_data;
    end
    build_expected();
    tick;
    start = 1'b0; cfg_wr_en = 1'b0;
    cyc = 1;
    while (!fin) begin
      vectors++;
      if (cfg_drop !== drop_pending) begin
        miscompares++;
        $display("FAIL cfg_drop cyc=%0d: got %b want %b", cyc, cfg_drop, drop_pending);
      end
      drop_pending = 0;
      cur = {set_valid, set_addr, set_key, set_xmask, set_data, set_clr};
      if (done === 1'b1) begin
        fin = 1;
      end else if (cyc > 200) begin
        vectors++; miscompares++;
        $display("FAIL done_timeout: got done=%b after %0d cycles want 1", done, cyc);
        fin = 1;
      end else begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_during_load cyc=%0d: got %b want 1", cyc, busy);
        end
        if (set_valid !== 1'b1) begin
          vectors++;
          if (cur !== '0) begin
            miscompares++;
            $display("FAIL idle_bus_zero cyc=%0d: got %h want 0", cyc, cur);
          end
        end
        if (prev_stall) begin
          vectors++;
          if (cur !== prev) begin
            miscompares++;
            $display("FAIL stall_hold cyc=%0d: got %h want %h", cyc, cur, prev);
          end
        end
        if (stall_addr >= 0) begin
          r = !(set_valid && set_addr == AW'(stall_addr) && stall_cnt < 5);
          if (!r) stall_cnt++;
        end else begin
          r = ($urandom_range(99) < ready_pct);
        end
        set_ready = r;
        prev_stall = set_valid && !r;
        if (prev_stall) stalls++;
        if (set_valid && r) begin
          t.addr = set_addr; t.key = set_key; t.xmask = set_xmask;
          t.data = set_data; t.clr = set_clr; t.cyc = cyc;
          got_q.push_back(t);
        end
        if (cyc == restart_at) start = 1'b1;
        if (cyc == wr_busy_at) begin
          cfg_slot = 2'($urandom_range(NR - 1)); cfg_en = 1'($urandom());
          cfg_key = rnd_key(); cfg_xmask = rnd_key(); cfg_data = DW'($urandom());
          cfg_wr_en = 1'b1;
          drop_pending = 1;
        end
        prev = cur;
        tick;
        start = 1'b0; cfg_wr_en = 1'b0;
        cyc++;
      end
    end
    set_ready = 1'b1;
    done_cyc = cyc;
    vectors++;
    if (busy !== 1'b0 || set_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL done_state: got busy=%b valid=%b want 0 0", busy, set_valid);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL txn_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i].addr !== exp_q[i].addr || got_q[i].key !== exp_q[i].key ||
          got_q[i].xmask !== exp_q[i].xmask || got_q[i].data !== exp_q[i].data ||
          got_q[i].clr !== exp_q[i].clr) begin
        miscompares++;
        $display("FAIL txn[%0d]: got addr=%h clr=%b data=%h key=%h want addr=%h clr=%b data=%h key=%h",
                 i, got_q[i].addr, got_q[i].clr, got_q[i].data, got_q[i].key,
                 exp_q[i].addr, exp_q[i].clr, exp_q[i].data, exp_q[i].key);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) tick;
    vectors++;
    if ({set_valid, set_clr, busy, done, cfg_drop, set_addr, set_key, set_xmask, set_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b addr=%h want all 0",
               set_valid, busy, done, set_addr);
    end
    rst = 1'b1;
    tick;
    vectors++;
    if ({set_valid, busy, done, cfg_drop} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b want 0000", {set_valid, busy, done, cfg_drop});
    end
  endtask

  task automatic setup_ref_table;
    cfg_write(0, 1'b1, {48'h555555555503, 48'h0}, {48'h0, 48'hFFFFFFFFFFFF}, 4'd0);
    cfg_write(1, 1'b1, {48'h555555555502, 48'h0}, {48'h0, 48'hFFFFFFFFFFFF}, 4'd1);
    cfg_write(2, 1'b1, {48'h555555555501, 48'h0}, {48'h0, 48'hFFFFFFFFFFFF}, 4'd2);
  endtask

  task automatic test_basic;
    int dc, st;
    setup_ref_table();
    run_load(100, -1, 1'b0, -1, -1, dc, st);
    vectors++;
    if (dc != NCLR + 4) begin
      miscompares++;
      $display("FAIL basic_done_cycle: got %0d want %0d", dc, NCLR + 4);
    end
    for (int j = 0; j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j].cyc != j + 1) begin
        miscompares++;
        $display("FAIL basic_txn_cycle[%0d]: got %0d want %0d", j, got_q[j].cyc, j + 1);
      end
    end
  endtask

  task automatic test_stall;
    int dc, st;
    run_load(100, 2, 1'b0, -1, -1, dc, st);
    vectors++;
    if (st != 5) begin
      miscompares++;
      $display("FAIL stall_cycles: got %0d want 5", st);
    end
  endtask

  task automatic test_disabled_and_drop;
    int dc, st;
    cfg_write(1, 1'b0, rnd_key(), rnd_key(), 4'hA);
    run_load(100, -1, 1'b0, -1, 2, dc, st);
    vectors++;
    if (dc > NCLR + 4) begin
      miscompares++;
      $display("FAIL disabled_done_cycle: got %0d want <= %0d", dc, NCLR + 4);
    end
    // Table must be unaffected by the refused write
    run_load(100, -1, 1'b0, -1, -1, dc, st);
  endtask

  task automatic test_busy_start;
    int dc, st;
    cfg_write(1, 1'b1, rnd_key(), rnd_key(), 4'h5);
    run_load(100, -1, 1'b0, 2, -1, dc, st);
  endtask

  task automatic test_bad_slot;
    cfg_write(3, 1'b1, rnd_key(), rnd_key(), 4'hF);
  endtask

  task automatic test_random;
    int dc, st;
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 2; w++)
        cfg_write($urandom_range(3), 1'($urandom()), rnd_key(), rnd_key(), DW'($urandom()));
      run_load($urandom_range(100, 30), -1, 1'($urandom()), -1, -1, dc, st);
      vectors++;
      if (dc > NCLR + NR + 1 + st) begin
        miscompares++;
        $display("FAIL random_done_cycle it=%0d: got %0d want <= %0d", it, dc, NCLR + NR + 1 + st);
      end
    end
  endtask

  task automatic test_reset_mid;
    int dc, st, n2;
    bit hit;
    setup_ref_table();
    hit = 0; n2 = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (set_valid && set_addr == 4'd2 && !set_clr) begin
        set_ready = 1'b0;
        n2++;
        if (n2 == 3) hit = 1;
      end else begin
        set_ready = 1'b1;
      end
      if (!hit) tick;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL reach_addr2_stall: got hit=%b want 1", hit);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({set_valid, set_clr, busy, done, cfg_drop, set_addr, set_key, set_xmask, set_data} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_mid: got valid=%b busy=%b done=%b addr=%h want all 0",
               set_valid, busy, done, set_addr);
    end
    tick;
    tick;
    #2 rst = 1'b1;
    set_ready = 1'b1;
    for (int i = 0; i < NR; i++) m_en[i] = 1'b0;
    run_load(100, -1, 1'b0, -1, -1, dc, st);
    vectors++;
    if (dc > NCLR + 4) begin
      miscompares++;
      $display("FAIL empty_done_cycle: got %0d want <= %0d", dc, NCLR + 4);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_en[i] = 1'b0; m_key[i] = '0; m_xmask[i] = '0; m_data[i] = '0;
    end
    test_reset();
    test_basic();
    test_stall();
    test_disabled_and_drop();
    test_busy_start();
    test_bad_slot();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
